adc_window_peak_detector: RTL

- Consumes the two 16-bit signed sample streams produced by the ZmodADC1410 controller wrapper on the system clock.
- Measures per-channel max, min and peak-to-peak over fixed windows of 2^WINDOW_LOG2 accepted samples.
- Publishes one result set per window with a single-cycle valid strobe; the downstream gain-control logic uses these results to choose relay gain/coupling.

---
 rtl/adc_peak_pkg.sv | 25 ++
 rtl/adc_peak_tracker.sv | 82 ++++++++
 rtl/adc_window_peak_detector.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/adc_peak_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_peak_pkg
// Description : Shared FSM encoding, extreme sample values and counter width
//               for the ADC window peak detector.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_peak_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    localparam int c_default_data_size = 16;

    localparam logic signed [c_default_data_size-1:0] c_most_pos = 16'sh7FFF;
    localparam logic signed [c_default_data_size-1:0] c_most_neg = 16'sh8000;

    // Wide enough for the largest legal window (WINDOW_LOG2 = 16).
    localparam int c_win_cnt_w = 16;

endpackage : adc_peak_pkg
`default_nettype wire

// File: rtl/adc_peak_tracker.sv
`default_nettype none
// ============================================================================
// Module      : adc_peak_tracker
// Description : Running max/min and sticky clip flag for one sample channel.
//               Clip detection is built only with ADC_PEAK_CLIP_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_peak_tracker #(
    parameter int DATA_SIZE = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_init,
    input  logic                        i_update,
    input  logic signed [DATA_SIZE-1:0] i_sample,
    input  logic signed [DATA_SIZE-1:0] i_threshold,
    output logic signed [DATA_SIZE-1:0] o_max_next,
    output logic signed [DATA_SIZE-1:0] o_min_next,
    output logic                        o_clip_next
);

    localparam logic signed [DATA_SIZE-1:0] c_pos = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [DATA_SIZE-1:0] c_neg = {1'b1, {(DATA_SIZE-1){1'b0}}};

    logic signed [DATA_SIZE-1:0] r_max;
    logic signed [DATA_SIZE-1:0] r_min;
    logic signed [DATA_SIZE-1:0] w_max_next;
    logic signed [DATA_SIZE-1:0] w_min_next;
    logic                        w_clip_next;

    // Next values include the current sample so the top can publish the
    // window on the same edge that accepts its last sample.
    always_comb begin
        w_max_next = r_max;
        w_min_next = r_min;
        if (i_update && (i_sample > r_max)) w_max_next = i_sample;
        if (i_update && (i_sample < r_min)) w_min_next = i_sample;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= c_neg;
            r_min <= c_pos;
        end else if (i_init) begin
            r_max <= c_neg;
            r_min <= c_pos;
        end else begin
            r_max <= w_max_next;
            r_min <= w_min_next;
        end
    end

`ifdef ADC_PEAK_CLIP_DETECT_EN
    logic                      r_clip;
    logic signed [DATA_SIZE:0] w_sample_ext;
    logic signed [DATA_SIZE:0] w_thr_ext;
    logic                      w_hit;

    // One extra bit keeps the negated threshold from overflowing.
    assign w_sample_ext = {i_sample[DATA_SIZE-1], i_sample};
    assign w_thr_ext    = {i_threshold[DATA_SIZE-1], i_threshold};
    assign w_hit        = (w_sample_ext >= w_thr_ext) || (w_sample_ext <= -w_thr_ext);
    assign w_clip_next  = r_clip | (i_update & w_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_clip <= 1'b0;
        else if (i_init) r_clip <= 1'b0;
        else             r_clip <= w_clip_next;
    end
`else
    logic w_unused_threshold;

    assign w_unused_threshold = ^i_threshold;
    assign w_clip_next        = 1'b0;
`endif

    assign o_max_next  = w_max_next;
    assign o_min_next  = w_min_next;
    assign o_clip_next = w_clip_next;

endmodule : adc_peak_tracker
`default_nettype wire

// File: rtl/adc_window_peak_detector.sv
`default_nettype none
// ============================================================================
// Module      : adc_window_peak_detector
// Description : Per-window max/min/peak-to-peak of two signed ADC channels.
//               Optional clip flags enabled by ADC_PEAK_CLIP_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_window_peak_detector
    import adc_peak_pkg::*;
#(
    parameter int                          DATA_SIZE      = c_default_data_size,
    parameter int                          WINDOW_LOG2    = 10,
    parameter logic signed [DATA_SIZE-1:0] CLIP_THRESHOLD = 16'sh7FF0
) (
    input  logic                 i_sys_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_init_done,
    input  logic                 i_sample_valid,
    input  logic [DATA_SIZE-1:0] i_data_ch1,
    input  logic [DATA_SIZE-1:0] i_data_ch2,
    output logic [DATA_SIZE-1:0] o_max_ch1,
    output logic [DATA_SIZE-1:0] o_min_ch1,
    output logic [DATA_SIZE:0]   o_pp_ch1,
    output logic [DATA_SIZE-1:0] o_max_ch2,
    output logic [DATA_SIZE-1:0] o_min_ch2,
    output logic [DATA_SIZE:0]   o_pp_ch2,
    output logic                 o_clip_ch1,
    output logic                 o_clip_ch2,
    output logic                 o_result_valid,
    output logic [15:0]          o_window_count,
    output logic                 o_busy
);

    localparam logic [c_win_cnt_w:0]   c_window_len = {{c_win_cnt_w{1'b0}}, 1'b1} << WINDOW_LOG2;
    localparam logic [c_win_cnt_w:0]   c_last_ext   = c_window_len - {{c_win_cnt_w{1'b0}}, 1'b1};
    localparam logic [c_win_cnt_w-1:0] c_last       = c_last_ext[c_win_cnt_w-1:0];
    localparam logic [c_win_cnt_w-1:0] c_cnt_one    = {{(c_win_cnt_w-1){1'b0}}, 1'b1};

    state_t                      r_state;
    logic [c_win_cnt_w-1:0]      r_count;
    logic [DATA_SIZE-1:0]        r_max_ch1, r_min_ch1, r_max_ch2, r_min_ch2;
    logic [DATA_SIZE:0]          r_pp_ch1, r_pp_ch2;
    logic                        r_clip_ch1, r_clip_ch2;
    logic                        r_result_valid;
    logic [15:0]                 r_window_count;
    logic                        r_busy;

    logic                        w_go;
    logic                        w_init;
    logic                        w_update;
    logic signed [DATA_SIZE-1:0] w_max1, w_min1, w_max2, w_min2;
    logic                        w_clip1, w_clip2;
    logic [DATA_SIZE:0]          w_pp1, w_pp2;

    assign w_go     = i_enable & i_init_done;
    assign w_init   = w_go & (r_state != ST_ACCUM);
    assign w_update = w_go & i_sample_valid & (r_state == ST_ACCUM);

    adc_peak_tracker #(.DATA_SIZE(DATA_SIZE)) u_trk_ch1 (
        .clk         (i_sys_clock),
        .rst_n       (i_reset),
        .i_init      (w_init),
        .i_update    (w_update),
        .i_sample    (i_data_ch1),
        .i_threshold (CLIP_THRESHOLD),
        .o_max_next  (w_max1),
        .o_min_next  (w_min1),
        .o_clip_next (w_clip1)
    );

    adc_peak_tracker #(.DATA_SIZE(DATA_SIZE)) u_trk_ch2 (
        .clk         (i_sys_clock),
        .rst_n       (i_reset),
        .i_init      (w_init),
        .i_update    (w_update),
        .i_sample    (i_data_ch2),
        .i_threshold (CLIP_THRESHOLD),
        .o_max_next  (w_max2),
        .o_min_next  (w_min2),
        .o_clip_next (w_clip2)
    );

    // Sign-extended difference; max >= min in any published window.
    assign w_pp1 = {w_max1[DATA_SIZE-1], w_max1} - {w_min1[DATA_SIZE-1], w_min1};
    assign w_pp2 = {w_max2[DATA_SIZE-1], w_max2} - {w_min2[DATA_SIZE-1], w_min2};

    always_ff @(posedge i_sys_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_max_ch1      <= '0;
            r_min_ch1      <= '0;
            r_pp_ch1       <= '0;
            r_max_ch2      <= '0;
            r_min_ch2      <= '0;
            r_pp_ch2       <= '0;
            r_clip_ch1     <= 1'b0;
            r_clip_ch2     <= 1'b0;
            r_result_valid <= 1'b0;
            r_window_count <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_state <= ST_ACCUM;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (!w_go) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (i_sample_valid) begin
                        if (r_count == c_last) begin
                            // Last sample of the window: publish on this edge.
                            r_state        <= ST_PUBLISH;
                            r_busy         <= 1'b0;
                            r_count        <= '0;
                            r_max_ch1      <= w_max1;
                            r_min_ch1      <= w_min1;
                            r_pp_ch1       <= w_pp1;
                            r_max_ch2      <= w_max2;
                            r_min_ch2      <= w_min2;
                            r_pp_ch2       <= w_pp2;
                            r_clip_ch1     <= w_clip1;
                            r_clip_ch2     <= w_clip2;
                            r_result_valid <= 1'b1;
                            r_window_count <= r_window_count + 16'd1;
                        end else begin
                            r_count <= r_count + c_cnt_one;
                        end
                    end
                end
                ST_PUBLISH: begin
                    r_count <= '0;
                    if (w_go) begin
                        r_state <= ST_ACCUM;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_max_ch1      = r_max_ch1;
    assign o_min_ch1      = r_min_ch1;
    assign o_pp_ch1       = r_pp_ch1;
    assign o_max_ch2      = r_max_ch2;
    assign o_min_ch2      = r_min_ch2;
    assign o_pp_ch2       = r_pp_ch2;
    assign o_clip_ch1     = r_clip_ch1;
    assign o_clip_ch2     = r_clip_ch2;
    assign o_result_valid = r_result_valid;
    assign o_window_count = r_window_count;
    assign o_busy         = r_busy;

endmodule : adc_window_peak_detector
`default_nettype wire
